// File: rtl/mine_engine.sv
// mine_engine: byte-serial Pearson proof-of-work miner.
// Latches a header and starting nonce on start, then hashes {header, nonce}
// until the hash has D leading zero bits or MAX_TRIES nonces were tried.
// Optional feature macro: MINE_ABORT_EN (enables the abort input).
module mine_engine #(
  parameter int unsigned      NONCE_W   = 39,
  parameter int unsigned      MSG_BYTES = (25 + NONCE_W) / 8,
  parameter int unsigned      TRY_W     = 32,
  parameter logic [TRY_W-1:0] MAX_TRIES = TRY_W'(32'h7FFF_FFFF)
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            previous_hash,
  input  logic [7:0]            amount,
  input  logic [7:0]            signature,
  input  logic                  transaction_direction,
  input  logic [NONCE_W-1:0]    start_nonce,
  input  logic [3:0]            difficulty,
  input  logic [2047:0]         random_table,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [NONCE_W-1:0]    nonce_out,
  output logic [7:0]            hash_out,
  output logic [TRY_W-1:0]      tries,
  output logic [25+NONCE_W-1:0] final_message
);

  localparam int unsigned MSG_W = 25 + NONCE_W;
  localparam int unsigned IDX_W = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_BYTES - 1);

  typedef enum logic [1:0] {IDLE, HASH, CHECK, DONE} state_t;

  state_t              state;
  logic [7:0]          prev_q;
  logic [7:0]          amount_q;
  logic [7:0]          sig_q;
  logic                dir_q;
  logic [3:0]          diff_q;
  logic [NONCE_W-1:0]  nonce_q;
  logic [7:0]          h_q;
  logic [IDX_W-1:0]    idx_q;

  logic [MSG_W-1:0]    msg_c;
  logic [7:0]          msg_bytes_c [MSG_BYTES];
  logic [7:0]          table_c [256];
  logic [7:0]          byte_c;
  logic [7:0]          h_next_c;
  logic                pass_c;
  logic [TRY_W-1:0]    tries_inc_c;
  logic                abort_hit_c;

  assign msg_c         = {prev_q, amount_q, sig_q, dir_q, nonce_q};
  assign final_message = {prev_q, amount_q, sig_q, dir_q, nonce_out};

  // Split the message into bytes, byte 0 being the most significant.
  for (genvar k = 0; k < MSG_BYTES; k++) begin : g_msg_bytes
    assign msg_bytes_c[k] = msg_c[8*(MSG_BYTES-k)-1 -: 8];
  end

  // Unpack the flat Pearson table into addressable entries.
  for (genvar i = 0; i < 256; i++) begin : g_table
    assign table_c[i] = random_table[8*i+7 -: 8];
  end

  // Hash step, difficulty test (clamped to 8) and incremented try count.
  always_comb begin
    byte_c      = msg_bytes_c[idx_q];
    h_next_c    = table_c[h_q ^ byte_c];
    pass_c      = ((h_q >> (4'd8 - ((diff_q > 4'd8) ? 4'd8 : diff_q))) == 8'd0);
    tries_inc_c = tries + TRY_W'(1);
  end

`ifdef MINE_ABORT_EN
  assign abort_hit_c = abort && ((state == HASH) || (state == CHECK));
`else
  logic unused_abort_c;
  assign unused_abort_c = abort;
  assign abort_hit_c    = 1'b0;
`endif

  // Mining FSM with registered status and result outputs.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state     <= IDLE;
      prev_q    <= '0;
      amount_q  <= '0;
      sig_q     <= '0;
      dir_q     <= 1'b0;
      diff_q    <= '0;
      nonce_q   <= '0;
      h_q       <= '0;
      idx_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      nonce_out <= '0;
      hash_out  <= '0;
      tries     <= '0;
    end else begin
      done <= 1'b0;
      if (abort_hit_c) begin
        // Abort wins over a same-edge pass; completed tries are kept.
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
        found <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              prev_q    <= previous_hash;
              amount_q  <= amount;
              sig_q     <= signature;
              dir_q     <= transaction_direction;
              diff_q    <= difficulty;
              nonce_q   <= start_nonce;
              h_q       <= '0;
              idx_q     <= '0;
              tries     <= '0;
              found     <= 1'b0;
              nonce_out <= '0;
              hash_out  <= '0;
              busy      <= 1'b1;
              state     <= HASH;
            end
          end
          HASH: begin
            h_q   <= h_next_c;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) state <= CHECK;
          end
          CHECK: begin
            hash_out  <= h_q;
            nonce_out <= nonce_q;
            tries     <= tries_inc_c;
            if (pass_c || (tries_inc_c == MAX_TRIES)) begin
              found <= pass_c;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              nonce_q <= nonce_q + NONCE_W'(1);
              h_q     <= '0;
              idx_q   <= '0;
              state   <= HASH;
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mine_engine.sv
// tb_mine_engine: directed checks of mine_engine with an identity Pearson
// table, so every hash is the XOR of the message bytes.
module tb_mine_engine;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          abort = 1'b0;
  logic [7:0]    previous_hash = '0;
  logic [7:0]    amount = '0;
  logic [7:0]    signature = '0;
  logic          transaction_direction = 1'b0;
  logic [38:0]   start_nonce = '0;
  logic [3:0]    difficulty = '0;
  logic [2047:0] random_table;

  logic          start_v   [3];
  logic          busy_v    [3];
  logic          done_v    [3];
  logic          found_v   [3];
  logic [38:0]   nonce_v   [3];
  logic [7:0]    hash_v    [3];
  logic [31:0]   tries_v   [3];
  logic [63:0]   fm_v      [3];

  int n_cmp = 0;
  int n_mis = 0;
  int edges;

  always #5 clock = ~clock;

  mine_engine u_dut (
    .clock(clock), .resetn(resetn), .start(start_v[0]), .abort(abort),
    .previous_hash(previous_hash), .amount(amount), .signature(signature),
    .transaction_direction(transaction_direction), .start_nonce(start_nonce),
    .difficulty(difficulty), .random_table(random_table),
    .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
    .nonce_out(nonce_v[0]), .hash_out(hash_v[0]), .tries(tries_v[0]),
    .final_message(fm_v[0])
  );

  mine_engine #(.MAX_TRIES(32'd16)) u_dut16 (
    .clock(clock), .resetn(resetn), .start(start_v[1]), .abort(abort),
    .previous_hash(previous_hash), .amount(amount), .signature(signature),
    .transaction_direction(transaction_direction), .start_nonce(start_nonce),
    .difficulty(difficulty), .random_table(random_table),
    .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
    .nonce_out(nonce_v[1]), .hash_out(hash_v[1]), .tries(tries_v[1]),
    .final_message(fm_v[1])
  );

  mine_engine #(.MAX_TRIES(32'd2)) u_dut2 (
    .clock(clock), .resetn(resetn), .start(start_v[2]), .abort(abort),
    .previous_hash(previous_hash), .amount(amount), .signature(signature),
    .transaction_direction(transaction_direction), .start_nonce(start_nonce),
    .difficulty(difficulty), .random_table(random_table),
    .busy(busy_v[2]), .done(done_v[2]), .found(found_v[2]),
    .nonce_out(nonce_v[2]), .hash_out(hash_v[2]), .tries(tries_v[2]),
    .final_message(fm_v[2])
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs in IDLE and pulse start on instance sel (start edge = edge 0).
  task automatic start_run(input int sel, input logic [7:0] prev, input logic [3:0] diff,
                           input logic [38:0] sn);
    repeat (2) @(negedge clock);
    previous_hash = prev;
    difficulty    = diff;
    start_nonce   = sn;
    start_v[sel]  = 1'b1;
    @(posedge clock);
    #1;
    start_v[sel]  = 1'b0;
  endtask

  // Count edges after the start edge until done is seen, bounded by max_edges.
  task automatic wait_done(input int sel, input int max_edges, output int n);
    n = 0;
    while (!done_v[sel] && n < max_edges) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic check_result(input string tag, input int sel, input logic f,
                              input logic [38:0] nn, input logic [7:0] hh, input logic [31:0] tt);
    check_eq({tag, "_found"}, 64'(found_v[sel]), 64'(f));
    check_eq({tag, "_nonce"}, 64'(nonce_v[sel]), 64'(nn));
    check_eq({tag, "_hash"},  64'(hash_v[sel]),  64'(hh));
    check_eq({tag, "_tries"}, 64'(tries_v[sel]), 64'(tt));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) random_table[8*i +: 8] = 8'(i);
    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    for (int s = 0; s < 3; s++) begin
      check_eq("rst_busy",  64'(busy_v[s]),  64'd0);
      check_eq("rst_done",  64'(done_v[s]),  64'd0);
    end
    check_result("rst", 0, 1'b0, 39'd0, 8'h00, 32'd0);
    resetn = 1'b1;

    // Zero header, difficulty 4: passes on the first try
    start_run(0, 8'h00, 4'd4, 39'd0);
    check_eq("zero_busy_start", 64'(busy_v[0]), 64'd1);
    wait_done(0, 100, edges);
    check_eq("zero_edges", 64'(edges), 64'd9);
    check_eq("zero_busy_done", 64'(busy_v[0]), 64'd0);
    check_result("zero", 0, 1'b1, 39'd0, 8'h00, 32'd1);
    check_eq("zero_msg", fm_v[0], 64'd0);
    @(posedge clock);
    #1;
    check_eq("zero_done_pulse", 64'(done_v[0]), 64'd0);
    check_eq("zero_hold_tries", 64'(tries_v[0]), 64'd1);

    // prev=F0, difficulty 4: nonce F0 is the first to clear the top nibble
    start_run(0, 8'hF0, 4'd4, 39'd0);
    wait_done(0, 3000, edges);
    check_eq("f0_edges", 64'(edges), 64'd2169);
    check_result("f0", 0, 1'b1, 39'h0F0, 8'h00, 32'd241);
    check_eq("f0_msg", fm_v[0], 64'hF000_0000_0000_00F0);

    // prev=F3, difficulty 4 and clamped 15
    start_run(0, 8'hF3, 4'd4, 39'd0);
    wait_done(0, 3000, edges);
    check_result("f3d4", 0, 1'b1, 39'h0F0, 8'h03, 32'd241);
    start_run(0, 8'hF3, 4'd15, 39'd0);
    wait_done(0, 3000, edges);
    check_eq("f3d15_edges", 64'(edges), 64'd2196);
    check_result("f3d15", 0, 1'b1, 39'h0F3, 8'h00, 32'd244);

    // MAX_TRIES=16 gives up after nonce 15
    start_run(1, 8'hF0, 4'd4, 39'd0);
    wait_done(1, 300, edges);
    check_eq("max16_edges", 64'(edges), 64'd144);
    check_result("max16", 1, 1'b0, 39'd15, 8'hFF, 32'd16);

    // All-ones nonce, difficulty 0: accepted immediately, hash 7F^FF^FF^FF^FF
    start_run(0, 8'h00, 4'd0, 39'h7F_FFFF_FFFF);
    wait_done(0, 100, edges);
    check_eq("d0_edges", 64'(edges), 64'd9);
    check_result("d0", 0, 1'b1, 39'h7F_FFFF_FFFF, 8'h7F, 32'd1);

    // MAX_TRIES=2 from all-ones nonce: second try uses the wrapped nonce 0
    start_run(2, 8'h01, 4'd8, 39'h7F_FFFF_FFFF);
    wait_done(2, 100, edges);
    check_eq("wrap_edges", 64'(edges), 64'd18);
    check_result("wrap", 2, 1'b0, 39'd0, 8'h01, 32'd2);

    // Abort raised after edge 20 of the F0 run
    start_run(0, 8'hF0, 4'd4, 39'd0);
    repeat (20) @(posedge clock);
    #1;
    abort = 1'b1;
    @(posedge clock);
    #1;
`ifdef MINE_ABORT_EN
    abort = 1'b0;
    check_eq("abort_done", 64'(done_v[0]), 64'd1);
    check_eq("abort_busy", 64'(busy_v[0]), 64'd0);
    check_result("abort", 0, 1'b0, 39'd1, 8'hF1, 32'd2);
`else
    abort = 1'b0;
    wait_done(0, 3000, edges);
    check_eq("abort_ign_edges", 64'(edges + 21), 64'd2169);
    check_result("abort_ign", 0, 1'b1, 39'h0F0, 8'h00, 32'd241);
`endif

    // Reset mid-run discards everything
    start_run(0, 8'hF0, 4'd4, 39'd0);
    repeat (20) @(posedge clock);
    #1;
    resetn = 1'b0;
    @(posedge clock);
    #1;
    check_eq("mrst_busy", 64'(busy_v[0]), 64'd0);
    check_eq("mrst_done", 64'(done_v[0]), 64'd0);
    check_eq("mrst_msg",  fm_v[0], 64'd0);
    check_result("mrst", 0, 1'b0, 39'd0, 8'h00, 32'd0);
    resetn = 1'b1;
    @(posedge clock);
    #1;
    check_eq("mrst_idle_busy", 64'(busy_v[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
